// File: rtl/bus_frame_receiver.sv
// ============================================================================
// bus_frame_receiver
// ----------------------------------------------------------------------------
// Serial receive endpoint for the single-wire frame bus. One bit is sampled
// per clock. Each 80-bit frame is deserialised, filtered on destination
// address, and checked for CRC-4 and stop bit. Accepted frames appear as a
// parallel word together with a one-cycle valid strobe.
//
// Frame layout (MSB first, one bit per clock):
//   start(1)=1 | src[3:0] | dst[3:0] | mod[1:0] | data[63:0] | crc[3:0] | stop(1)=0
//
// CRC-4, polynomial x^4+x+1, initial value 0. It covers the 74 bits from src
// through data.
//
// Handshake: rx_valid, crc_err and frame_err are single-cycle strobes with no
// back-pressure. At most one of them is high in any cycle. rx_data, rx_src
// and rx_mod are valid while rx_valid is high, and they hold their value
// until the next accepted frame.
//
// Parameters:
//   MY_ADDR   - this node's address
//   BCAST_EN  - when 1, destination 4'hF is accepted as well
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   bus_in     in   serial line, idles at 0
//   rx_data    out  payload of the last accepted frame
//   rx_src     out  sender address of the last accepted frame
//   rx_mod     out  mode field of the last accepted frame
//   rx_valid   out  one-cycle pulse, accepted frame on rx_*
//   crc_err    out  one-cycle pulse, address-matched frame failed CRC
//   frame_err  out  one-cycle pulse, address-matched frame had bad stop bit
//   busy       out  high from start-bit detection until frame end
//   dbg_state  out  current FSM state, for observation only
// ============================================================================
module bus_frame_receiver #(
    parameter logic [3:0] MY_ADDR  = 4'd1,
    parameter bit         BCAST_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        bus_in,
    output logic [63:0] rx_data,
    output logic [3:0]  rx_src,
    output logic [1:0]  rx_mod,
    output logic        rx_valid,
    output logic        crc_err,
    output logic        frame_err,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PAY  = 3'd2,
        S_CRC  = 3'd3,
        S_STOP = 3'd4
    } state_t;

    state_t       r_state;
    logic [6:0]   r_cnt;      // bit index within src..crc, 0..77
    logic [73:0]  r_shift;    // src, dst, mod, data
    logic [3:0]   r_crc;      // running CRC over the shifted-in bits
    logic [3:0]   r_rcrc;     // CRC field received from the line
    logic         r_match;    // address filter result for this frame
    logic [63:0]  r_rx_data;
    logic [3:0]   r_rx_src;
    logic [1:0]   r_rx_mod;
    logic         r_rx_valid;
    logic         r_crc_err;
    logic         r_frame_err;
    logic         r_busy;

    logic [3:0]   w_dst;
    logic         w_addr_hit;
    logic [3:0]   w_crc_next;

    // One serial CRC step: shift left, fold the polynomial in on feedback.
    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = c[3] ^ b;
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    // While the last dst bit is on the line, the other three dst bits are
    // already in the low end of the shift register.
    assign w_dst      = {r_shift[2:0], bus_in};
    assign w_addr_hit = (w_dst == MY_ADDR) || (BCAST_EN && (w_dst == 4'hF));
    assign w_crc_next = crc4_step(r_crc, bus_in);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 7'd0;
            r_shift     <= 74'd0;
            r_crc       <= 4'd0;
            r_rcrc      <= 4'd0;
            r_match     <= 1'b0;
            r_rx_data   <= 64'd0;
            r_rx_src    <= 4'd0;
            r_rx_mod    <= 2'd0;
            r_rx_valid  <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Strobes default low, so every pulse lasts exactly one clock.
            r_rx_valid  <= 1'b0;
            r_crc_err   <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus_in) begin
                        r_state <= S_HDR;
                        r_cnt   <= 7'd0;
                        r_crc   <= 4'd0;
                        r_match <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_HDR, S_PAY: begin
                    r_shift <= {r_shift[72:0], bus_in};
                    r_crc   <= w_crc_next;
                    r_cnt   <= r_cnt + 7'd1;
                    if (r_cnt == 7'd7) begin
                        r_match <= w_addr_hit;
                    end
                    if (r_cnt == 7'd9) begin
                        r_state <= S_PAY;
                    end
                    if (r_cnt == 7'd73) begin
                        r_state <= S_CRC;
                    end
                end
                S_CRC: begin
                    r_rcrc <= {r_rcrc[2:0], bus_in};
                    r_cnt  <= r_cnt + 7'd1;
                    if (r_cnt == 7'd77) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Always return to IDLE. A stop bit of 1 is never
                    // taken as the next start bit.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (r_match) begin
                        if (bus_in) begin
                            r_frame_err <= 1'b1;
                        end else if (r_crc != r_rcrc) begin
                            r_crc_err <= 1'b1;
                        end else begin
                            r_rx_src   <= r_shift[73:70];
                            r_rx_mod   <= r_shift[65:64];
                            r_rx_data  <= r_shift[63:0];
                            r_rx_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_src    = r_rx_src;
    assign rx_mod    = r_rx_mod;
    assign rx_valid  = r_rx_valid;
    assign crc_err   = r_crc_err;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Testbench for bus_frame_receiver. Two receivers share one bus line: one
// with broadcast enabled and one without. A reference model built from the
// frame rules predicts the strobes and the held outputs of each receiver.
module tb_bus_frame_receiver;

  logic clock = 1'b0;
  logic reset_n;
  logic bus_in;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [63:0] a_rx_data, b_rx_data;
  logic [3:0]  a_rx_src, b_rx_src;
  logic [1:0]  a_rx_mod, b_rx_mod;
  logic        a_rx_valid, b_rx_valid;
  logic        a_crc_err, b_crc_err;
  logic        a_frame_err, b_frame_err;
  logic        a_busy, b_busy;
  logic [2:0]  a_dbg_state, b_dbg_state;

  bus_frame_receiver #(.MY_ADDR(4'd1), .BCAST_EN(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus_in(bus_in),
    .rx_data(a_rx_data), .rx_src(a_rx_src), .rx_mod(a_rx_mod),
    .rx_valid(a_rx_valid), .crc_err(a_crc_err), .frame_err(a_frame_err),
    .busy(a_busy), .dbg_state(a_dbg_state)
  );

  bus_frame_receiver #(.MY_ADDR(4'd1), .BCAST_EN(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus_in(bus_in),
    .rx_data(b_rx_data), .rx_src(b_rx_src), .rx_mod(b_rx_mod),
    .rx_valid(b_rx_valid), .crc_err(b_crc_err), .frame_err(b_frame_err),
    .busy(b_busy), .dbg_state(b_dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int last_valid_cyc = -1;

  // Model of the held outputs: index 0 is dut_a, index 1 is dut_b.
  logic [63:0] exp_data[2];
  logic [3:0]  exp_src[2];
  logic [1:0]  exp_mod[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // CRC as the remainder of polynomial long division of msg*x^4 by x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [73:0] msg);
    logic [77:0] m;
    m = {msg, 4'b0000};
    for (int i = 77; i >= 4; i--) begin
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    end
    return m[3:0];
  endfunction

  function automatic logic [2:0] strobes(input int d);
    return (d == 0) ? {a_rx_valid, a_crc_err, a_frame_err}
                    : {b_rx_valid, b_crc_err, b_frame_err};
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? a_busy : b_busy;
  endfunction

  task automatic check_held(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_data", tag, d), (d == 0) ? a_rx_data : b_rx_data, exp_data[d]);
      chk($sformatf("%s_d%0d_src", tag, d), (d == 0) ? a_rx_src : b_rx_src, {60'd0, exp_src[d]});
      chk($sformatf("%s_d%0d_mod", tag, d), (d == 0) ? a_rx_mod : b_rx_mod, {62'd0, exp_mod[d]});
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      exp_data[d] = 64'd0;
      exp_src[d]  = 4'd0;
      exp_mod[d]  = 2'd0;
    end
  endtask

  // Drive bus_in low for n cycles. Both receivers must stay quiet.
  task automatic idle(input string tag, input int n);
    logic [3:0] acc;
    acc = 4'd0;
    bus_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      acc = acc | {|strobes(0), |strobes(1), a_busy, b_busy};
    end
    chk({tag, "_quiet"}, {60'd0, acc}, 64'd0);
    check_held(tag);
  endtask

  function automatic logic [79:0] build_frame(input logic [3:0] src, input logic [3:0] dst,
                                              input logic [1:0] mode, input logic [63:0] data,
                                              input logic stop_bit);
    logic [73:0] body;
    body = {src, dst, mode, data};
    return {1'b1, body, ref_crc(body), stop_bit};
  endfunction

  // Send one frame with no leading or trailing gap. flip_bit >= 0 corrupts
  // that data bit after the CRC has been computed.
  task automatic send_frame(input string tag, input logic [3:0] src, input logic [3:0] dst,
                            input logic [1:0] mode, input logic [63:0] data,
                            input int flip_bit, input logic stop_bit);
    logic [79:0] f;
    logic        crc_ok;
    logic        match;
    logic [2:0]  exp_strb[2];
    logic [2:0]  mid_strb[2];
    int          busy_hi[2];
    f = build_frame(src, dst, mode, data, stop_bit);
    if (flip_bit >= 0) f[5 + flip_bit] = ~f[5 + flip_bit];
    crc_ok = (ref_crc(f[78:5]) == f[4:1]);
    for (int d = 0; d < 2; d++) begin
      match = (dst == 4'd1) || ((d == 0) && (dst == 4'hF));
      if (!match)       exp_strb[d] = 3'b000;
      else if (f[0])    exp_strb[d] = 3'b001;
      else if (!crc_ok) exp_strb[d] = 3'b010;
      else              exp_strb[d] = 3'b100;
      mid_strb[d] = 3'b000;
      busy_hi[d] = 0;
    end
    for (int k = 0; k < 80; k++) begin
      bus_in = f[79 - k];
      tick();
      if (k < 79) begin
        for (int d = 0; d < 2; d++) begin
          busy_hi[d] += int'(busy_of(d));
          mid_strb[d] = mid_strb[d] | strobes(d);
        end
      end
    end
    if (a_rx_valid) last_valid_cyc = cyc;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_d%0d_busy_cycles", tag, d), busy_hi[d], 79);
      chk($sformatf("%s_d%0d_mid_strobe", tag, d), {61'd0, mid_strb[d]}, 64'd0);
      chk($sformatf("%s_d%0d_strobe", tag, d), {61'd0, strobes(d)}, {61'd0, exp_strb[d]});
      chk($sformatf("%s_d%0d_busy_end", tag, d), {63'd0, busy_of(d)}, 64'd0);
      if (exp_strb[d] == 3'b100) begin
        exp_data[d] = data;
        exp_src[d]  = src;
        exp_mod[d]  = mode;
      end
    end
    check_held(tag);
  endtask

  initial begin
    logic [79:0] f;
    int t1;
    int t2;
    logic [3:0] dst;
    int kind;
    int gap;

    // Reset, then a long idle stretch.
    clear_model();
    reset_n = 1'b0;
    bus_in  = 1'b0;
    #3;
    check_held("reset");
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_d%0d_strb_busy", d), {60'd0, strobes(d), busy_of(d)}, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    idle("idle200", 200);

    // Good frame for this node.
    send_frame("good", 4'd2, 4'd1, 2'd1, 64'h1, -1, 1'b0);
    chk("good_data_value", a_rx_data, 64'h1);
    idle("post_good", 3);

    // Address filtering.
    send_frame("dst3", 4'd5, 4'd3, 2'd2, 64'hDEAD_BEEF_0000_0001, -1, 1'b0);
    idle("post_dst3", 2);
    send_frame("bcast", 4'd7, 4'hF, 2'd3, 64'h0123_4567_89AB_CDEF, -1, 1'b0);
    idle("post_bcast", 2);

    // CRC error, then a bad stop bit.
    send_frame("crcerr", 4'd2, 4'd1, 2'd0, 64'h55AA_55AA_1234_5678, 0, 1'b0);
    idle("post_crcerr", 2);
    send_frame("stoperr", 4'd3, 4'd1, 2'd2, 64'hFEED_0000_0000_0042, -1, 1'b1);
    idle("post_stoperr", 1);

    // Back-to-back frames with no idle gap.
    send_frame("b2b_1", 4'd4, 4'd1, 2'd1, 64'hA5A5_0000_FFFF_1234, -1, 1'b0);
    t1 = last_valid_cyc;
    send_frame("b2b_2", 4'd6, 4'd1, 2'd2, 64'h0, -1, 1'b0);
    t2 = last_valid_cyc;
    chk("b2b_spacing", t2 - t1, 80);
    idle("post_b2b", 2);

    // Reset in the middle of a frame.
    f = build_frame(4'd9, 4'd1, 2'd3, 64'hCAFE_F00D_0000_0009, 1'b0);
    for (int k = 0; k < 40; k++) begin
      bus_in = f[79 - k];
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    clear_model();
    check_held("midrst");
    for (int d = 0; d < 2; d++)
      chk($sformatf("midrst_d%0d_strb_busy", d), {60'd0, strobes(d), busy_of(d)}, 64'd0);
    bus_in = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    idle("post_midrst", 100);
    send_frame("after_rst", 4'd8, 4'd1, 2'd1, 64'h1111_2222_3333_4444, -1, 1'b0);
    idle("post_after_rst", 2);

    // Randomised frames with mixed destinations, errors and gaps.
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    dst = 4'd1;
        2:       dst = 4'hF;
        default: dst = 4'($urandom_range(0, 15));
      endcase
      kind = $urandom_range(0, 4);
      send_frame($sformatf("rnd%0d", n), 4'($urandom_range(0, 15)), dst,
                 2'($urandom_range(0, 3)), {$urandom, $urandom},
                 (kind == 3) ? $urandom_range(0, 63) : -1, (kind == 4));
      gap = $urandom_range(0, 2);
      if (gap > 0) idle($sformatf("rnd%0d_gap", n), gap);
    end
    idle("final", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
